// File: rtl/aes_key_pkg.sv
// Shared constants, state encoding, Rcon table and forward S-box for the AES-128 key-schedule walker.
package aes_key_pkg;

   localparam int KEY_W      = 128;
   localparam int NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FWD    = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } key_state_t;

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [2047:0] sh;
      sh = SBOX << {b, 3'b000};
      return sh[2047:2040];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups on one 32-bit word.
// Purely combinational, no handshake.
module aes_subword
   import aes_key_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                    sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_unroll.sv
// Inverse AES-128 key schedule: streams round keys 10..0 from one working key (FWD_EXPAND_EN: key_i is the cipher key, expanded first).
// Latency start->first key 1 cycle (11 with FWD_EXPAND_EN), then 1 key/cycle; key_ready_i low holds key/idx/valid stable.
module aes_key_unroll #(
   parameter int NUM_ROUNDS = aes_key_pkg::NUM_ROUNDS,
   parameter int KEY_W      = aes_key_pkg::KEY_W
) (
   input  logic             clk_i,
   input  logic             reset_key_n_i,
   input  logic             start_i,
   input  logic [KEY_W-1:0] key_i,
   output logic             busy_o,
   output logic             key_valid_o,
   input  logic             key_ready_i,
   output logic [KEY_W-1:0] key_o,
   output logic [3:0]       key_idx_o,
   output logic             key_last_o,
   output logic             done_o
);
   import aes_key_pkg::*;

   key_state_t       state_q;
   logic [KEY_W-1:0] key_q;
   logic [3:0]       idx_q;
   logic             busy_q, valid_q, last_q, done_q;

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] sub_in, sub_out;
   logic [KEY_W-1:0] inv_key_d;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   aes_subword u_subword (
      .word_i (sub_in),
      .word_o (sub_out)
   );

   // Inverse step recovers w3 of round r-1 first; SubWord acts on that recovered word.
   logic [31:0] inv_w3;
   assign inv_w3    = w3 ^ w2;
   assign inv_key_d = {w0 ^ sub_out ^ {rcon(idx_q), 24'h0}, w1 ^ w0, w2 ^ w1, inv_w3};

`ifdef FWD_EXPAND_EN
   logic [KEY_W-1:0] fwd_key_d;
   logic [31:0]      f0, f1, f2;
   assign sub_in    = (state_q == FWD) ? {w3[23:0], w3[31:24]} : {inv_w3[23:0], inv_w3[31:24]};
   assign f0        = w0 ^ sub_out ^ {rcon(4'(idx_q + 4'd1)), 24'h0};
   assign f1        = w1 ^ f0;
   assign f2        = w2 ^ f1;
   assign fwd_key_d = {f0, f1, f2, w3 ^ f2};
`else
   assign sub_in    = {inv_w3[23:0], inv_w3[31:24]};
`endif

   always_ff @(posedge clk_i) begin
      if (!reset_key_n_i) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  key_q  <= key_i;
                  busy_q <= 1'b1;
`ifdef FWD_EXPAND_EN
                  state_q <= FWD;
                  idx_q   <= '0;
`else
                  state_q <= STREAM;
                  idx_q   <= 4'(NUM_ROUNDS);
                  valid_q <= 1'b1;
`endif
               end
            end
`ifdef FWD_EXPAND_EN
            FWD: begin
               key_q <= fwd_key_d;
               if (idx_q == 4'(NUM_ROUNDS - 1)) begin
                  state_q <= STREAM;
                  idx_q   <= 4'(NUM_ROUNDS);
                  valid_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
`endif
            STREAM: begin
               if (valid_q && key_ready_i) begin
                  if (idx_q == 4'd0) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     key_q  <= inv_key_d;
                     idx_q  <= idx_q - 4'd1;
                     last_q <= (idx_q == 4'd1);
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign key_valid_o = valid_q;
   assign key_o       = key_q;
   assign key_idx_o   = idx_q;
   assign key_last_o  = last_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_aes_key_unroll.sv
// Directed bench for aes_key_unroll using the FIPS-197 A.1 key schedule.
module tb_aes_key_unroll;

   logic         clk = 1'b0;
   logic         rst_n, start, ready;
   logic [127:0] key_in;
   logic         busy, valid, last, done;
   logic [127:0] key_out;
   logic [3:0]   idx;

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_key [0:10];

`ifdef FWD_EXPAND_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 1;
`endif

   always #5 clk = ~clk;

   aes_key_unroll dut (
      .clk_i         (clk),
      .reset_key_n_i (rst_n),
      .start_i       (start),
      .key_i         (key_in),
      .busy_o        (busy),
      .key_valid_o   (valid),
      .key_ready_i   (ready),
      .key_o         (key_out),
      .key_idx_o     (idx),
      .key_last_o    (last),
      .done_o        (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] start_key();
`ifdef FWD_EXPAND_EN
      return exp_key[0];
`else
      return exp_key[10];
`endif
   endfunction

   task automatic launch(input string tag);
      int n;
      key_in = start_key();
      start  = 1'b1;
      step();
      start  = 1'b0;
      n = 1;
      while (!valid && n < 40) begin
         step();
         n++;
      end
      chk(tag, 128'(n), 128'(LAT));
   endtask

   initial begin
      int xfers, n;
      bit injected, seen_done;

      exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst_n  = 1'b0;
      start  = 1'b0;
      ready  = 1'b0;
      key_in = '1;
      step();
      step();
      chk("rst_busy",  128'(busy),  128'd0);
      chk("rst_valid", 128'(valid), 128'd0);
      chk("rst_key",   key_out,     128'd0);
      chk("rst_idx",   128'(idx),   128'd0);
      chk("rst_last",  128'(last),  128'd0);
      chk("rst_done",  128'(done),  128'd0);
      rst_n = 1'b1;
      step();

      // Full-rate stream with ready held high before valid.
      ready = 1'b1;
      launch("a_latency");
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("a_key%0d", 10 - i),  key_out,      exp_key[10 - i]);
         chk($sformatf("a_idx%0d", 10 - i),  128'(idx),    128'(10 - i));
         chk($sformatf("a_vld%0d", 10 - i),  128'(valid),  128'd1);
         chk($sformatf("a_last%0d", 10 - i), 128'(last),   128'(i == 10));
         chk($sformatf("a_done%0d", 10 - i), 128'(done),   128'd0);
         step();
      end
      chk("a_done_pulse", 128'(done),  128'd1);
      chk("a_done_vld",   128'(valid), 128'd0);
      chk("a_done_last",  128'(last),  128'd0);
      chk("a_done_busy",  128'(busy),  128'd1);
      key_in = '0;
      start  = 1'b1;
      step();
      start = 1'b0;
      chk("a_idle_done", 128'(done),  128'd0);
      chk("a_idle_busy", 128'(busy),  128'd0);
      chk("a_keep_key",  key_out,     exp_key[0]);
      step();
      chk("a_start_in_done_busy",  128'(busy),  128'd0);
      chk("a_start_in_done_valid", 128'(valid), 128'd0);

      // Backpressure 1,0,0,1 with an ignored restart at idx 5.
      launch("b_latency");
      xfers = 0;
      injected = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         start = 1'b0;
         if (done) begin
            seen_done = 1'b1;
         end else begin
            ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (valid) begin
               chk("b_key", key_out, (xfers <= 10) ? exp_key[10 - xfers] : 128'hx);
               chk("b_idx", 128'(idx), 128'(10 - xfers));
               if (ready) xfers++;
            end
            if (valid && idx == 4'd5 && !injected) begin
               key_in   = '0;
               start    = 1'b1;
               injected = 1'b1;
            end
         end
         step();
      end
      chk("b_xfers",    128'(xfers),     128'd11);
      chk("b_done",     128'(seen_done), 128'd1);
      chk("b_injected", 128'(injected),  128'd1);
      chk("b_end_busy", 128'(busy),      128'd0);
      chk("b_end_key",  key_out,         exp_key[0]);

      // Reset asserted while idx 7 is presented.
      ready = 1'b1;
      launch("c_latency");
      n = 0;
      while (idx != 4'd7 && n < 40) begin
         step();
         n++;
      end
      chk("c_reach_idx7", 128'(idx), 128'd7);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("c_rst_valid", 128'(valid), 128'd0);
      chk("c_rst_busy",  128'(busy),  128'd0);
      chk("c_rst_key",   key_out,     128'd0);
      chk("c_rst_idx",   128'(idx),   128'd0);
      chk("c_rst_done",  128'(done),  128'd0);
      step();
      chk("c_no_done", 128'(done), 128'd0);
      chk("c_idle",    128'(busy), 128'd0);
      launch("c_relaunch_latency");
      chk("c_relaunch_key", key_out,   exp_key[10]);
      chk("c_relaunch_idx", 128'(idx), 128'd10);
      n = 0;
      while (!done && n < 40) begin
         step();
         n++;
      end
      chk("c_drain_done", 128'(done), 128'd1);
      chk("c_drain_key",  key_out,    exp_key[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
